// File: rtl/sand_pkg.sv
// Shared types and constants for the sand frame stepper.
package sand_pkg;

    typedef enum logic [1:0] {
        AIR        = 2'b00,
        SAND       = 2'b01,
        SAND_MOVED = 2'b10,
        WALL       = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_FLOOR  = 3'd1,
        ST_RD_REGION = 3'd2,
        ST_STEP      = 3'd3,
        ST_FLUSH     = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Moved marks only live inside one step; memory always sees plain sand.
    function automatic logic [1:0] strip_mark(input logic [1:0] c);
        return (c == SAND_MOVED) ? SAND : c;
    endfunction

endpackage

// File: rtl/sand_row_rule.sv
// Combinational update of one region row falling onto its floor row.
module sand_row_rule
    import sand_pkg::*;
#(
    parameter int ROW_CELLS = 16
) (
    input  logic [2*ROW_CELLS-1:0] region,
    input  logic [2*ROW_CELLS-1:0] floor,
    input  logic [ROW_CELLS-1:0]   tie,
    output logic [2*ROW_CELLS-1:0] new_region,
    output logic [2*ROW_CELLS-1:0] new_floor
);

    // floor padded with a WALL on each side so edge cells need no special case
    logic [1:0] f [ROW_CELLS+2];

    // Cells resolve in ascending order; each sees the floor as left by lower cells.
    always_comb begin
        f[0]           = WALL;
        f[ROW_CELLS+1] = WALL;
        for (int i = 0; i < ROW_CELLS; i++) begin
            f[i+1] = floor[2*i +: 2];
        end
        new_region = region;
        for (int i = 0; i < ROW_CELLS; i++) begin
            if (region[2*i +: 2] == SAND) begin
                if (f[i+1] == AIR) begin
                    f[i+1]               = SAND_MOVED;
                    new_region[2*i +: 2] = AIR;
                end else if (f[i] == AIR && f[i+2] == AIR) begin
                    if (tie[i]) f[i]   = SAND_MOVED;
                    else        f[i+2] = SAND_MOVED;
                    new_region[2*i +: 2] = AIR;
                end else if (f[i] == AIR) begin
                    f[i]                 = SAND_MOVED;
                    new_region[2*i +: 2] = AIR;
                end else if (f[i+2] == AIR) begin
                    f[i+2]               = SAND_MOVED;
                    new_region[2*i +: 2] = AIR;
                end
            end
        end
        new_floor = '0;
        for (int i = 0; i < ROW_CELLS; i++) begin
            new_floor[2*i +: 2] = f[i+1];
        end
    end

endmodule

// File: rtl/sand_frame_stepper.sv
// Sweeps a frame bottom-to-top, one row pair per cycle, using a one-row floor cache.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// RD_FLOOR  | read row ROWS-1
// RD_REGION | cache row ROWS-1 as floor, read row ROWS-2
// STEP      | update row r onto floor, write row r+1, read row r-1
// FLUSH     | write cached row 0
// DONE      | one-cycle done pulse
module sand_frame_stepper
    import sand_pkg::*;
#(
    parameter int ROW_CELLS  = 16,
    parameter int ROWS       = 64,
    parameter int ADDR_W     = $clog2(ROWS),
    parameter int RANDOM_TIE = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic                          spout_en,
    input  logic [$clog2(ROW_CELLS)-1:0]  spout_col,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [2*ROW_CELLS-1:0]        rd_data,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [2*ROW_CELLS-1:0]        wr_data
);

    localparam int COL_W = $clog2(ROW_CELLS);

    localparam logic [2:0] S_IDLE      = ST_IDLE;
    localparam logic [2:0] S_RD_FLOOR  = ST_RD_FLOOR;
    localparam logic [2:0] S_RD_REGION = ST_RD_REGION;
    localparam logic [2:0] S_STEP      = ST_STEP;
    localparam logic [2:0] S_FLUSH     = ST_FLUSH;
    localparam logic [2:0] S_DONE      = ST_DONE;

    logic [2:0]             state;
    logic [ADDR_W-1:0]      r;
    logic [2*ROW_CELLS-1:0] cache;
    logic [15:0]            lfsr;
    logic                   spout_en_q;
    logic [COL_W-1:0]       spout_col_q;

    logic [2*ROW_CELLS-1:0] region;
    logic [2*ROW_CELLS-1:0] new_region;
    logic [2*ROW_CELLS-1:0] new_floor;
    logic [2*ROW_CELLS-1:0] floor_clean;
    logic [2*ROW_CELLS-1:0] cache_clean;
    logic [ROW_CELLS-1:0]   tie;
    logic [15:0]            lfsr_next;

    assign lfsr_next = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

    // Per-column diagonal preference: 1 = left
    always_comb begin
        tie = '0;
        for (int i = 0; i < ROW_CELLS; i++) begin
            tie[i] = (RANDOM_TIE != 0) ? lfsr[i % 16] : (i % 2 == 1);
        end
    end

    // Spout drops sand into row 0 only when that cell is empty on read
    always_comb begin
        region = rd_data;
        if (state == S_STEP && r == '0 && spout_en_q) begin
            for (int i = 0; i < ROW_CELLS; i++) begin
                if (COL_W'(i) == spout_col_q && rd_data[2*i +: 2] == AIR) begin
                    region[2*i +: 2] = SAND;
                end
            end
        end
    end

    sand_row_rule #(
        .ROW_CELLS (ROW_CELLS)
    ) u_rule (
        .region     (region),
        .floor      (cache),
        .tie        (tie),
        .new_region (new_region),
        .new_floor  (new_floor)
    );

    // Marks are dropped on every path to memory
    always_comb begin
        floor_clean = '0;
        cache_clean = '0;
        for (int i = 0; i < ROW_CELLS; i++) begin
            floor_clean[2*i +: 2] = strip_mark(new_floor[2*i +: 2]);
            cache_clean[2*i +: 2] = strip_mark(cache[2*i +: 2]);
        end
    end

    // Sequencer: r counts down from ROWS-2; terminal count 0 ends the sweep
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            r           <= '0;
            cache       <= '0;
            lfsr        <= LFSR_SEED;
            spout_en_q  <= 1'b0;
            spout_col_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_RD_FLOOR;
                        spout_en_q  <= spout_en;
                        spout_col_q <= spout_col;
                    end
                end
                S_RD_FLOOR:  state <= S_RD_REGION;
                S_RD_REGION: begin
                    cache <= rd_data;
                    r     <= ADDR_W'(ROWS - 2);
                    state <= S_STEP;
                end
                S_STEP: begin
                    cache <= new_region;
                    lfsr  <= lfsr_next;
                    if (r != '0) r     <= r - ADDR_W'(1);
                    else         state <= S_FLUSH;
                end
                S_FLUSH: state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes decoded from state and row counter only
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_RD_FLOOR: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(ROWS - 1);
            end
            S_RD_REGION: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(ROWS - 2);
            end
            S_STEP: begin
                wr_en   = 1'b1;
                wr_addr = r + ADDR_W'(1);
                wr_data = floor_clean;
                if (r != '0) begin
                    rd_en   = 1'b1;
                    rd_addr = r - ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = cache_clean;
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_sand_frame_stepper.sv
// Directed bench: small 4x2 parity-tie instance and 8x8 LFSR-tie instance.
module tb_sand_frame_stepper;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int marks_cnt = 0;

    // instance A: ROW_CELLS=4, ROWS=2, parity tie
    logic        a_start = 1'b0, a_spout_en = 1'b0;
    logic [1:0]  a_spout_col = '0;
    logic        a_busy, a_done, a_rd_en, a_wr_en;
    logic [0:0]  a_rd_addr, a_wr_addr;
    logic [7:0]  a_rd_data, a_wr_data;
    logic [7:0]  mem_a [2];
    logic        a_ld = 1'b0;
    logic [0:0]  a_ld_addr = '0;
    logic [7:0]  a_ld_data = '0;

    // instance B: ROW_CELLS=8, ROWS=8, LFSR tie
    logic        b_start = 1'b0, b_spout_en = 1'b0;
    logic [2:0]  b_spout_col = '0;
    logic        b_busy, b_done, b_rd_en, b_wr_en;
    logic [2:0]  b_rd_addr, b_wr_addr;
    logic [15:0] b_rd_data, b_wr_data;
    logic [15:0] mem_b [8];
    logic        b_ld = 1'b0;
    logic [2:0]  b_ld_addr = '0;
    logic [15:0] b_ld_data = '0;

    sand_frame_stepper #(.ROW_CELLS(4), .ROWS(2), .RANDOM_TIE(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .spout_en(a_spout_en),
        .spout_col(a_spout_col), .busy(a_busy), .done(a_done), .rd_en(a_rd_en),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_en(a_wr_en),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    sand_frame_stepper #(.ROW_CELLS(8), .ROWS(8), .RANDOM_TIE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .spout_en(b_spout_en),
        .spout_col(b_spout_col), .busy(b_busy), .done(b_done), .rd_en(b_rd_en),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_en(b_wr_en),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    function automatic logic has_mark(input logic [15:0] w);
        for (int i = 0; i < 8; i++) if (w[2*i +: 2] == 2'b10) return 1'b1;
        return 1'b0;
    endfunction

    // frame RAMs with 1-cycle read latency, plus a bench-side load port
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
        if (a_wr_en) mem_a[a_wr_addr] <= a_wr_data;
        else if (a_ld) mem_a[a_ld_addr] <= a_ld_data;
        if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
        if (b_wr_en) mem_b[b_wr_addr] <= b_wr_data;
        else if (b_ld) mem_b[b_ld_addr] <= b_ld_data;
        marks_cnt <= marks_cnt + int'(a_wr_en && has_mark({8'h00, a_wr_data}))
                               + int'(b_wr_en && has_mark(b_wr_data));
    end

    task automatic load_a(input logic [7:0] r0, input logic [7:0] r1);
        a_ld = 1'b1; a_ld_addr = 1'b0; a_ld_data = r0; @(negedge clk);
        a_ld_addr = 1'b1; a_ld_data = r1; @(negedge clk);
        a_ld = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] rows [8]);
        b_ld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_ld_addr = 3'(i); b_ld_data = rows[i]; @(negedge clk);
        end
        b_ld = 1'b0;
    endtask

    task automatic sweep_a(output int done_cyc, output int busy_cnt);
        a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        done_cyc = -1; busy_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (a_busy) busy_cnt++;
            if (a_done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c > done_cyc) break;
        end
    endtask

    task automatic sweep_b(input logic sp_en, input logic [2:0] sp_col,
                           output int done_cyc, output int busy_cnt,
                           output logic [2:0] rd3, output logic [2:0] wr3);
        b_spout_en = sp_en; b_spout_col = sp_col; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        done_cyc = -1; busy_cnt = 0; rd3 = 'x; wr3 = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (b_busy) busy_cnt++;
            if (c == 3) begin rd3 = b_rd_addr; wr3 = b_wr_addr; end
            if (b_done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0 && c > done_cyc) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data} !== 12'h0) begin
            n_err++; $display("FAIL reset_a: got %b want all zero",
                {a_busy, a_done, a_rd_en, a_wr_en, a_rd_addr, a_wr_addr, a_wr_data});
        end
        n_cmp++;
        if ({b_busy, b_done, b_rd_en, b_wr_en, b_rd_addr, b_wr_addr, b_wr_data} !== 26'h0) begin
            n_err++; $display("FAIL reset_b: got %b want all zero",
                {b_busy, b_done, b_rd_en, b_wr_en, b_rd_addr, b_wr_addr, b_wr_data});
        end
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_busy, b_busy, a_done, b_done} !== 4'b0) begin
            n_err++; $display("FAIL idle_after_reset: got %b want 0000", {a_busy, b_busy, a_done, b_done});
        end
    endtask

    task automatic test_basic_fall();
        int dc, bc;
        load_a(8'h04, 8'h00);
        sweep_a(dc, bc);
        n_cmp++; if (dc !== 5) begin n_err++; $display("FAIL basic_done_cycle: got %0d want 5", dc); end
        n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 4", bc); end
        n_cmp++; if (mem_a[0] !== 8'h00) begin n_err++; $display("FAIL basic_row0: got %h want 00", mem_a[0]); end
        n_cmp++; if (mem_a[1] !== 8'h04) begin n_err++; $display("FAIL basic_row1: got %h want 04", mem_a[1]); end
    endtask

    task automatic test_parity_tie();
        int dc, bc;
        load_a(8'h10, 8'h30);   // even col 2 blocked below: goes right
        sweep_a(dc, bc);
        n_cmp++; if (mem_a[1] !== 8'h70) begin n_err++; $display("FAIL tie_even_row1: got %h want 70", mem_a[1]); end
        n_cmp++; if (mem_a[0] !== 8'h00) begin n_err++; $display("FAIL tie_even_row0: got %h want 00", mem_a[0]); end
        load_a(8'h04, 8'h0C);   // odd col 1 blocked below: goes left
        sweep_a(dc, bc);
        n_cmp++; if (mem_a[1] !== 8'h0D) begin n_err++; $display("FAIL tie_odd_row1: got %h want 0d", mem_a[1]); end
    endtask

    task automatic test_contention();
        int dc, bc;
        load_a(8'h11, 8'hF3);
        sweep_a(dc, bc);
        n_cmp++; if (mem_a[1] !== 8'hF7) begin n_err++; $display("FAIL contention_row1: got %h want f7", mem_a[1]); end
        n_cmp++; if (mem_a[0] !== 8'h10) begin n_err++; $display("FAIL contention_row0: got %h want 10", mem_a[0]); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        load_a(8'h00, 8'h00);
        a_start = 1'b1; @(posedge clk); #1 a_start = 1'b0;
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_first_done: got none want pulse"); end
        a_start = 1'b1;           // held through DONE: must be ignored there
        @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_in_done: busy got %b want 0", a_busy); end
        @(negedge clk);
        a_start = 1'b0;
        n_cmp++; if (a_busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: busy got %b want 1", a_busy); end
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL b2b_second_done: got none want pulse"); end
        @(negedge clk);
    endtask

    task automatic test_random_tie();
        logic [15:0] f [8];
        int dc, bc; logic [2:0] rd3, wr3;
        // lfsr at the row-0 step (6 advances from ACE1) is 3879: bit1=0 right, bit6=1 left
        for (int i = 0; i < 8; i++) f[i] = 16'h0000;
        f[0] = 16'h1004; f[1] = 16'h300C;
        load_b(f);
        sweep_b(1'b0, 3'd0, dc, bc, rd3, wr3);
        n_cmp++; if (mem_b[1] !== 16'h341C) begin n_err++; $display("FAIL lfsr_tie_row1: got %h want 341c", mem_b[1]); end
        n_cmp++; if (mem_b[0] !== 16'h0000) begin n_err++; $display("FAIL lfsr_tie_row0: got %h want 0000", mem_b[0]); end
    endtask

    task automatic test_multi_sweep();
        logic [15:0] f [8];
        int dc, bc; logic [2:0] rd3, wr3;
        for (int i = 0; i < 8; i++) f[i] = 16'h0000;
        f[0] = 16'h0001;
        load_b(f);
        sweep_b(1'b0, 3'd0, dc, bc, rd3, wr3);
        n_cmp++; if (dc !== 11) begin n_err++; $display("FAIL b_done_cycle: got %0d want 11", dc); end
        n_cmp++; if (bc !== 10) begin n_err++; $display("FAIL b_busy_cycles: got %0d want 10", bc); end
        n_cmp++; if ({rd3, wr3} !== {3'd5, 3'd7}) begin
            n_err++; $display("FAIL b_first_step_addr: got rd %0d wr %0d want rd 5 wr 7", rd3, wr3);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem_b[i] !== ((i == 1) ? 16'h0001 : 16'h0000)) begin
                n_err++; $display("FAIL one_sweep_row%0d: got %h want %h", i, mem_b[i], (i == 1) ? 16'h0001 : 16'h0000);
            end
        end
        repeat (6) sweep_b(1'b0, 3'd0, dc, bc, rd3, wr3);
        n_cmp++; if (mem_b[7] !== 16'h0001) begin n_err++; $display("FAIL seven_sweeps_row7: got %h want 0001", mem_b[7]); end
        n_cmp++; if (mem_b[6] !== 16'h0000) begin n_err++; $display("FAIL seven_sweeps_row6: got %h want 0000", mem_b[6]); end
        sweep_b(1'b0, 3'd0, dc, bc, rd3, wr3);
        n_cmp++; if (mem_b[7] !== 16'h0001) begin n_err++; $display("FAIL settled_row7: got %h want 0001", mem_b[7]); end
    endtask

    task automatic test_spout();
        logic [15:0] f [8];
        int dc, bc; logic [2:0] rd3, wr3;
        for (int i = 0; i < 8; i++) f[i] = 16'h0000;
        load_b(f);
        sweep_b(1'b1, 3'd5, dc, bc, rd3, wr3);
        n_cmp++; if (mem_b[1] !== 16'h0400) begin n_err++; $display("FAIL spout_row1: got %h want 0400", mem_b[1]); end
        n_cmp++; if (mem_b[0] !== 16'h0000) begin n_err++; $display("FAIL spout_row0: got %h want 0000", mem_b[0]); end
        sweep_b(1'b0, 3'd5, dc, bc, rd3, wr3);
        n_cmp++; if ({mem_b[2], mem_b[1], mem_b[0]} !== {16'h0400, 16'h0000, 16'h0000}) begin
            n_err++; $display("FAIL spout_off_rows210: got %h %h %h want 0400 0000 0000", mem_b[2], mem_b[1], mem_b[0]);
        end
        n_cmp++; if (marks_cnt !== 0) begin n_err++; $display("FAIL marks_written: got %0d want 0", marks_cnt); end
    endtask

    task automatic test_reset_mid_sweep();
        logic [15:0] f [8];
        int n_done, n_wr;
        for (int i = 0; i < 8; i++) f[i] = 16'h0000;
        f[0] = 16'h0001; f[6] = 16'h0001;
        load_b(f);
        b_spout_en = 1'b0; b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (b_wr_en !== 1'b1) begin n_err++; $display("FAIL mid_step_wr_en: got %b want 1", b_wr_en); end
        reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({b_wr_en, b_busy, b_done} !== 3'b000) begin
            n_err++; $display("FAIL reset_mid_outputs: got %b want 000", {b_wr_en, b_busy, b_done});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_done = 0; n_wr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_done) n_done++;
            if (b_wr_en) n_wr++;
        end
        n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL reset_mid_done: got %0d want 0", n_done); end
        n_cmp++; if (n_wr !== 0) begin n_err++; $display("FAIL reset_mid_writes: got %0d want 0", n_wr); end
        n_cmp++; if ({mem_b[7], mem_b[6], mem_b[1], mem_b[0]} !== {16'h0001, 16'h0000, 16'h0000, 16'h0001}) begin
            n_err++; $display("FAIL reset_mid_rows7610: got %h %h %h %h want 0001 0000 0000 0001",
                mem_b[7], mem_b[6], mem_b[1], mem_b[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_fall();
        test_parity_tie();
        test_contention();
        test_back_to_back();
        test_random_tie();
        test_multi_sweep();
        test_spout();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
